// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM state encoding
// and the default memory data width.
package inst_fetch_unit_pkg;

    localparam int IFU_ST_LEN   = 2;
    localparam int MEM_DATA_LEN = 64;

    typedef enum logic [IFU_ST_LEN-1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } ifu_state_e;

    function automatic logic pc_misaligned(input logic [1:0] pc_low);
        return |pc_low;
    endfunction

endpackage

// File: rtl/inst_fetch_unit.sv
// Multicycle instruction fetch stage: takes a pc, issues one 64-bit memory read,
// selects the 32-bit lane and holds it for decode. Handles redirect flushes and faults.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int INST_W = 32,
    parameter int MEM_W  = MEM_DATA_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    output logic              pc_ready_o,
    input  logic              redirect_i,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_rsp_valid_i,
    input  logic [MEM_W-1:0]  mem_rsp_data_i,
    input  logic              mem_rsp_err_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              inst_fault_o
);

    ifu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              fault_q, fault_d;
    logic              pc_fire;
    logic [INST_W-1:0] rsp_lane;

    assign pc_ready_o = ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && inst_ready_i))
                        && !redirect_i;
    assign pc_fire    = pc_valid_i && pc_ready_o;
    assign rsp_lane   = pc_q[2] ? mem_rsp_data_i[MEM_W-1 -: INST_W] : mem_rsp_data_i[INST_W-1:0];

    assign mem_req_valid_o = (state_q == ST_REQ);
    assign mem_req_addr_o  = {pc_q[ADDR_W-1:3], 3'b000};
    assign inst_valid_o    = (state_q == ST_HOLD);
    assign inst_o          = inst_q;
    assign inst_pc_o       = pc_q;
    assign inst_fault_o    = fault_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            drop_q  <= 1'b0;
            inst_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    // A request is never retracted once issued; a redirect only marks its response for discard.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        inst_d  = inst_q;
        fault_d = fault_q;

        unique case (state_q)
            ST_IDLE: begin
            end
            ST_REQ: begin
                if (redirect_i) drop_d = 1'b1;
                if (mem_req_ready_i) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rsp_valid_i) begin
                    if (drop_q || redirect_i) begin
                        drop_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        inst_d  = mem_rsp_err_i ? '0 : rsp_lane;
                        fault_d = mem_rsp_err_i;
                        state_d = ST_HOLD;
                    end
                end else if (redirect_i) begin
                    drop_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_i || inst_ready_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Misaligned pcs never touch the bus; they go straight to decode as a fault.
        if (pc_fire) begin
            pc_d = pc_i;
            if (pc_misaligned(pc_i[1:0])) begin
                inst_d  = '0;
                fault_d = 1'b1;
                state_d = ST_HOLD;
            end else begin
                state_d = ST_REQ;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: transaction-level model plus a responding
// memory slave, with directed scenarios and literal spot checks.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] pc_i = '0;
    logic        pc_valid_i = 1'b0;
    logic        pc_ready_o;
    logic        redirect_i = 1'b0;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b1;
    logic [63:0] mem_req_addr_o;
    logic        mem_rsp_valid_i = 1'b0;
    logic [63:0] mem_rsp_data_i = '0;
    logic        mem_rsp_err_i = 1'b0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [63:0] inst_pc_o;
    logic        inst_fault_o;

    int n_checks = 0;
    int n_passed = 0;

    int          rsp_delay = 1;
    logic [63:0] err_addr  = '1;

    inst_fetch_unit dut (
        .clk             (clk),
        .rst             (rst),
        .pc_i            (pc_i),
        .pc_valid_i      (pc_valid_i),
        .pc_ready_o      (pc_ready_o),
        .redirect_i      (redirect_i),
        .mem_req_valid_o (mem_req_valid_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_rsp_valid_i (mem_rsp_valid_i),
        .mem_rsp_data_i  (mem_rsp_data_i),
        .mem_rsp_err_i   (mem_rsp_err_i),
        .inst_valid_o    (inst_valid_o),
        .inst_ready_i    (inst_ready_i),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .inst_fault_o    (inst_fault_o)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] mem_data(input logic [63:0] a);
        case (a)
            64'h0000_0000_8000_0000: return 64'h00100073_00000013;
            64'h0000_0000_8000_0008: return 64'hDEADBEEF_CAFEF00D;
            default:                 return {~a[31:0], a[31:0] ^ a[63:32] ^ 32'h12345678};
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        else
            n_passed++;
    endtask

    // Transaction-level model: at most one fetch waiting for the bus, one awaiting
    // its response, and one instruction held for decode.
    logic        m_req = 1'b0, m_req_drop = 1'b0;
    logic [63:0] m_req_pc = '0;
    logic        m_rsp = 1'b0, m_rsp_drop = 1'b0;
    logic [63:0] m_rsp_pc = '0;
    logic        m_held = 1'b0, m_held_fault = 1'b0;
    logic [63:0] m_held_pc = '0;
    logic [31:0] m_held_inst = '0;
    logic [63:0] m_word;
    logic        m_accept;

    function automatic logic model_pc_ready();
        return (!(m_req || m_rsp || m_held) || (m_held && inst_ready_i)) && !redirect_i;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_req = 1'b0; m_req_drop = 1'b0; m_rsp = 1'b0; m_rsp_drop = 1'b0;
            m_held = 1'b0;
        end else begin
            m_accept = pc_valid_i && model_pc_ready();
            if (m_held && (redirect_i || inst_ready_i)) m_held = 1'b0;
            if (m_rsp) begin
                if (mem_rsp_valid_i) begin
                    m_rsp = 1'b0;
                    if (!(m_rsp_drop || redirect_i)) begin
                        m_word       = mem_data({m_rsp_pc[63:3], 3'b000});
                        m_held       = 1'b1;
                        m_held_pc    = m_rsp_pc;
                        m_held_fault = ({m_rsp_pc[63:3], 3'b000} == err_addr);
                        m_held_inst  = m_held_fault ? 32'h0 :
                                       (m_rsp_pc[2] ? m_word[63:32] : m_word[31:0]);
                    end
                end else if (redirect_i) begin
                    m_rsp_drop = 1'b1;
                end
            end else if (m_req) begin
                if (redirect_i) m_req_drop = 1'b1;
                if (mem_req_ready_i) begin
                    m_req      = 1'b0;
                    m_rsp      = 1'b1;
                    m_rsp_pc   = m_req_pc;
                    m_rsp_drop = m_req_drop;
                end
            end
            if (m_accept) begin
                if (pc_i[1:0] != 2'b00) begin
                    m_held       = 1'b1;
                    m_held_pc    = pc_i;
                    m_held_inst  = 32'h0;
                    m_held_fault = 1'b1;
                end else begin
                    m_req      = 1'b1;
                    m_req_pc   = pc_i;
                    m_req_drop = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("pc_ready", 64'(pc_ready_o), 64'(model_pc_ready()));
            check("mem_req_valid", 64'(mem_req_valid_o), 64'(m_req));
            if (m_req) check("mem_req_addr", mem_req_addr_o, {m_req_pc[63:3], 3'b000});
            check("inst_valid", 64'(inst_valid_o), 64'(m_held));
            if (m_held) begin
                check("inst", 64'(inst_o), 64'(m_held_inst));
                check("inst_pc", inst_pc_o, m_held_pc);
                check("inst_fault", 64'(inst_fault_o), 64'(m_held_fault));
            end
        end
    end

    // Memory slave: answers each accepted request rsp_delay cycles after acceptance.
    initial begin
        logic        acc_now;
        logic [63:0] addr_now, rsp_addr;
        int          rsp_cnt;
        rsp_cnt  = 0;
        rsp_addr = '0;
        forever begin
            @(negedge clk);
            acc_now  = rst && mem_req_valid_o && mem_req_ready_i;
            addr_now = mem_req_addr_o;
            @(posedge clk);
            #1;
            mem_rsp_valid_i = 1'b0;
            mem_rsp_err_i   = 1'b0;
            mem_rsp_data_i  = '0;
            if (!rst) begin
                rsp_cnt = 0;
            end else begin
                if (acc_now) begin
                    rsp_cnt  = rsp_delay;
                    rsp_addr = addr_now;
                end
                if (rsp_cnt > 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        mem_rsp_valid_i = 1'b1;
                        mem_rsp_data_i  = mem_data(rsp_addr);
                        mem_rsp_err_i   = (rsp_addr == err_addr);
                    end
                end
            end
        end
    end

    task automatic apply_stimulus(input logic pv, input logic [63:0] pc,
                                  input logic ir, input logic rd);
        pc_valid_i   = pv;
        pc_i         = pc;
        inst_ready_i = ir;
        redirect_i   = rd;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_inst_valid(input int budget);
        int n = 0;
        while (!inst_valid_o && n < budget) begin
            step();
            n++;
        end
        check("inst_valid_timeout", 64'(inst_valid_o), 64'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("reset_pc_ready", 64'(pc_ready_o), 64'd1);
        check("reset_inst_valid", 64'(inst_valid_o), 64'd0);
        check("reset_mem_req_valid", 64'(mem_req_valid_o), 64'd0);
        check("reset_inst", 64'(inst_o), 64'd0);
        step();

        $display("[TB] basic fetch");
        apply_stimulus(1'b1, 64'h8000_0004, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);
        check("basic_req_valid", 64'(mem_req_valid_o), 64'd1);
        check("basic_req_addr", mem_req_addr_o, 64'h8000_0000);
        step();
        check("basic_not_yet_valid", 64'(inst_valid_o), 64'd0);
        step();
        check("basic_inst_valid", 64'(inst_valid_o), 64'd1);
        check("basic_inst", 64'(inst_o), 64'h0010_0073);
        check("basic_inst_pc", inst_pc_o, 64'h8000_0004);
        check("basic_fault", 64'(inst_fault_o), 64'd0);
        apply_stimulus(1'b0, 64'h0, 1'b1, 1'b0);
        step();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);

        $display("[TB] backpressure");
        mem_req_ready_i = 1'b0;
        apply_stimulus(1'b1, 64'h8000_0000, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("bp_req_valid", 64'(mem_req_valid_o), 64'd1);
            check("bp_req_addr", mem_req_addr_o, 64'h8000_0000);
            step();
        end
        mem_req_ready_i = 1'b1;
        step();
        wait_inst_valid(4);
        check("bp_inst", 64'(inst_o), 64'h0000_0013);
        apply_stimulus(1'b1, 64'h8000_0008, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("bp_hold_pc_ready", 64'(pc_ready_o), 64'd0);
            check("bp_hold_inst", 64'(inst_o), 64'h0000_0013);
            step();
        end

        $display("[TB] back-to-back");
        apply_stimulus(1'b1, 64'h8000_0008, 1'b1, 1'b0);
        check("b2b_pc_ready", 64'(pc_ready_o), 64'd1);
        step();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);
        check("b2b_req_valid", 64'(mem_req_valid_o), 64'd1);
        check("b2b_req_addr", mem_req_addr_o, 64'h8000_0008);
        wait_inst_valid(4);
        check("b2b_inst", 64'(inst_o), 64'hCAFE_F00D);
        check("b2b_inst_pc", inst_pc_o, 64'h8000_0008);
        apply_stimulus(1'b0, 64'h0, 1'b1, 1'b0);
        step();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);

        $display("[TB] redirect in WAIT");
        rsp_delay = 2;
        apply_stimulus(1'b1, 64'h8000_0040, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b1);
        step();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check("redir_no_inst_valid", 64'(inst_valid_o), 64'd0);
            step();
        end
        rsp_delay = 1;
        apply_stimulus(1'b1, 64'h8000_0200, 1'b0, 1'b1);
        check("redir_idle_pc_ready", 64'(pc_ready_o), 64'd0);
        step();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);
        check("redir_idle_no_req", 64'(mem_req_valid_o), 64'd0);
        apply_stimulus(1'b1, 64'h8000_0100, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);
        wait_inst_valid(5);
        check("after_redir_inst", 64'(inst_o), 64'h9234_5778);
        check("after_redir_pc", inst_pc_o, 64'h8000_0100);
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b1);
        step();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);
        check("redir_hold_drop", 64'(inst_valid_o), 64'd0);

        $display("[TB] faults");
        apply_stimulus(1'b1, 64'h8000_0002, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);
        check("misalign_no_req", 64'(mem_req_valid_o), 64'd0);
        check("misalign_valid", 64'(inst_valid_o), 64'd1);
        check("misalign_fault", 64'(inst_fault_o), 64'd1);
        check("misalign_inst", 64'(inst_o), 64'd0);
        check("misalign_pc", inst_pc_o, 64'h8000_0002);
        apply_stimulus(1'b0, 64'h0, 1'b1, 1'b0);
        step();
        err_addr = 64'h8000_0010;
        apply_stimulus(1'b1, 64'h8000_0010, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);
        wait_inst_valid(5);
        check("err_fault", 64'(inst_fault_o), 64'd1);
        check("err_inst", 64'(inst_o), 64'd0);
        apply_stimulus(1'b0, 64'h0, 1'b1, 1'b0);
        step();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);
        err_addr = '1;

        $display("[TB] async reset");
        mem_req_ready_i = 1'b0;
        apply_stimulus(1'b1, 64'h8000_0020, 1'b0, 1'b0);
        step();
        apply_stimulus(1'b0, 64'h0, 1'b0, 1'b0);
        check("arst_pre_req_valid", 64'(mem_req_valid_o), 64'd1);
        #1 rst = 1'b0;
        #1;
        check("arst_req_valid", 64'(mem_req_valid_o), 64'd0);
        check("arst_inst_valid", 64'(inst_valid_o), 64'd0);
        repeat (2) step();
        rst = 1'b1;
        mem_req_ready_i = 1'b1;
        step();
        check("arst_release_pc_ready", 64'(pc_ready_o), 64'd1);
        check("arst_release_req_valid", 64'(mem_req_valid_o), 64'd0);
        repeat (2) step();

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
